// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;

    logic        v_req;
    logic        v_wr;
    logic [15:0] v_addr;
    logic [3:0]  v_cnt;
    logic [15:0] v_wdata;
    logic        v_gnt;
    logic [3:0]  v_beat;
    logic        v_rvalid;
    logic [15:0] v_rdata;
    logic [3:0]  v_rindex;
    logic        v_done;

    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] dataOut;
    logic [15:0] DataIn;
    logic        busy;

    modport master (
        output f_req, f_addr, v_req, v_wr, v_addr, v_cnt, v_wdata, DataIn,
        input  f_gnt, f_rvalid, f_rdata, v_gnt, v_beat, v_rvalid, v_rdata,
               v_rindex, v_done, Addr, RD, WR, dataOut, busy
    );

    modport slave (
        input  f_req, f_addr, v_req, v_wr, v_addr, v_cnt, v_wdata, DataIn,
        output f_gnt, f_rvalid, f_rdata, v_gnt, v_beat, v_rvalid, v_rdata,
               v_rindex, v_done, Addr, RD, WR, dataOut, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/vector-burst arbiter onto one memory port
module mem_arbiter (
    input  logic         Clk1,
    input  logic         Reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, VBURST = 2'd2} state_t;

    state_t      state, state_nx;
    logic        last_vec, last_vec_nx;
    logic [3:0]  beat_q, beat_nx;
    logic [15:0] f_addr_q, v_base_q;
    logic [3:0]  v_cnt_q;
    logic        v_wr_q;
    logic        arb_point, f_elig, v_elig, last_beat;
    logic        rd_c;

    logic        t1_valid, t1_vec, t1_last;
    logic [3:0]  t1_idx;
    logic        t2_valid, t2_vec, t2_last;
    logic [3:0]  t2_idx;
    logic [15:0] rdata_q;
    logic        st_done_q;

    assign last_beat = (state == VBURST) && (beat_q == v_cnt_q);

    // The owner of the current bus cycle is masked so a lingering req is not re-granted.
    always_comb begin
        state_nx    = state;
        last_vec_nx = last_vec;
        beat_nx     = beat_q;
        arb_point   = (state == IDLE) || (state == FETCH) || last_beat;
        f_elig      = bus.f_req && (state != FETCH);
        v_elig      = bus.v_req && (state != VBURST);
        if (arb_point) begin
            if (f_elig && (!v_elig || last_vec)) begin
                state_nx    = FETCH;
                last_vec_nx = 1'b0;
            end else if (v_elig) begin
                state_nx    = VBURST;
                last_vec_nx = 1'b1;
                beat_nx     = 4'd0;
            end else begin
                state_nx    = IDLE;
            end
        end else begin
            beat_nx = beat_q + 4'd1;
        end
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            last_vec <= 1'b1;
            beat_q   <= 4'd0;
            f_addr_q <= 16'h0;
            v_base_q <= 16'h0;
            v_cnt_q  <= 4'd0;
            v_wr_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            last_vec <= last_vec_nx;
            beat_q   <= beat_nx;
            if (arb_point && state_nx == FETCH) begin
                f_addr_q <= bus.f_addr;
            end
            if (arb_point && state_nx == VBURST) begin
                v_base_q <= bus.v_addr;
                v_cnt_q  <= bus.v_cnt;
                v_wr_q   <= bus.v_wr;
            end
        end
    end

    always_comb begin
        rd_c        = 1'b0;
        bus.WR      = 1'b0;
        bus.Addr    = 16'h0;
        bus.dataOut = 16'h0;
        bus.f_gnt   = 1'b0;
        bus.v_gnt   = 1'b0;
        bus.v_beat  = 4'd0;
        case (state)
            FETCH: begin
                bus.Addr  = f_addr_q;
                rd_c      = 1'b1;
                bus.f_gnt = 1'b1;
            end
            VBURST: begin
                bus.Addr   = v_base_q + {12'h0, beat_q};
                bus.v_gnt  = 1'b1;
                bus.v_beat = beat_q;
                if (v_wr_q) begin
                    bus.WR      = 1'b1;
                    bus.dataOut = bus.v_wdata;
                end else begin
                    rd_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.RD   = rd_c;
    assign bus.busy = (state != IDLE);

    // Read-return tags travel independently of the FSM so returns can overlap the next grant.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            t1_valid  <= 1'b0;
            t1_vec    <= 1'b0;
            t1_last   <= 1'b0;
            t1_idx    <= 4'd0;
            t2_valid  <= 1'b0;
            t2_vec    <= 1'b0;
            t2_last   <= 1'b0;
            t2_idx    <= 4'd0;
            rdata_q   <= 16'h0;
            st_done_q <= 1'b0;
        end else begin
            t1_valid  <= rd_c;
            t1_vec    <= (state == VBURST);
            t1_last   <= last_beat;
            t1_idx    <= beat_q;
            t2_valid  <= t1_valid;
            t2_vec    <= t1_vec;
            t2_last   <= t1_last;
            t2_idx    <= t1_idx;
            if (t1_valid) begin
                rdata_q <= bus.DataIn;
            end
            st_done_q <= last_beat && v_wr_q;
        end
    end

    assign bus.f_rvalid = t2_valid && !t2_vec;
    assign bus.v_rvalid = t2_valid && t2_vec;
    assign bus.f_rdata  = bus.f_rvalid ? rdata_q : 16'h0;
    assign bus.v_rdata  = bus.v_rvalid ? rdata_q : 16'h0;
    assign bus.v_rindex = bus.v_rvalid ? t2_idx : 4'd0;
    assign bus.v_done   = (bus.v_rvalid && t2_last) || st_done_q;
endmodule
